// File: rtl/ysyx_25040111_lsu_axi_if.sv
// AXI4 master port of the load/store unit: AW, W, B, AR and R channels.
// The LSU drives it through the master modport; the crossbar or a bench
// model sits on the slave side.
interface ysyx_25040111_lsu_axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // write address channel
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    // write data channel
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    // write response channel
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic [3:0]          bid;
    // read address channel
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    // read data channel
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [3:0]          rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );
endinterface

// File: rtl/ysyx_25040111_lsu_axi.sv
// Parametrised AXI4 load/store unit. Takes one load/store request from the
// execute stage, performs a single-beat AXI4 transaction and returns the
// extended load data plus a response code. One transaction in flight.
// Response codes: 00 ok, 01 misaligned/illegal size, 10 bus error, 11 timeout.
module ysyx_25040111_lsu_axi #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023,
    parameter int AXI_ID  = 0
) (
    input  logic              clk,
    input  logic              reset,
    // request from EXU
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic              req_sign,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // response to EXU
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        resp_err,
    // AXI4 master port
    ysyx_25040111_lsu_axi_if.master io_master
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // largest legal req_size: 2 (word) on a 32-bit bus, 3 (dword) on 64-bit
    localparam logic [1:0]       MAX_SIZE = 2'(OFF_W);
    localparam bit               TO_EN    = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_BUS     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AWW,
        S_B,
        S_RESP
    } state_t;

    state_t state_q, next_state;

    // latched request
    logic              wen_q;
    logic              sign_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // progress of the two write channels inside AWW
    logic aw_done_q;
    logic w_done_q;

    // cycles spent in bus states for the current transaction
    logic [CNT_W-1:0] cnt_q;

    // registered response
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        err_q;

    // per-cycle events decided by the FSM
    logic accept;
    logic req_bad;
    logic req_misaligned;
    logic aw_hs;
    logic w_hs;
    logic rd_capture;
    logic b_capture;
    logic to_fire;
    logic in_bus;
    logic timeout_hit;

    // lane shaping
    logic [OFF_W-1:0]  off;
    logic [7:0]        strb_base;
    logic [63:0]       rd_shift;
    logic [63:0]       load_ext;
    logic [DATA_W-1:0] load_data;

    assign off         = addr_q[OFF_W-1:0];
    assign in_bus      = (state_q == S_AR) || (state_q == S_R) ||
                         (state_q == S_AWW) || (state_q == S_B);
    assign timeout_hit = TO_EN && (cnt_q >= CNT_LAST);

    // Request legality: offset must be a multiple of the access size and
    // the size must fit the bus width.
    always_comb begin
        req_misaligned = 1'b0;
        case (req_size)
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = |req_addr[1:0];
            default: req_misaligned = |req_addr[2:0];
        endcase
    end

    assign req_bad = req_misaligned || (req_size > MAX_SIZE);

    // Byte-enable pattern for the access size, before shifting to the lane.
    always_comb begin
        strb_base = 8'h00;
        case (size_q)
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    end

    // Load result: move the addressed bytes down to bit 0, then extend.
    // Done at 64 bits and truncated so one description serves both widths.
    always_comb begin
        rd_shift = 64'(io_master.rdata >> {off, 3'b000});
        load_ext = rd_shift;
        case (size_q)
            2'd0:    load_ext = {{56{sign_q & rd_shift[7]}},  rd_shift[7:0]};
            2'd1:    load_ext = {{48{sign_q & rd_shift[15]}}, rd_shift[15:0]};
            2'd2:    load_ext = {{32{sign_q & rd_shift[31]}}, rd_shift[31:0]};
            default: load_ext = rd_shift;
        endcase
    end

    assign load_data = load_ext[DATA_W-1:0];

    // Fixed AXI fields: single beat, INCR, constant ID.
    assign io_master.awid    = 4'(AXI_ID);
    assign io_master.arid    = 4'(AXI_ID);
    assign io_master.awlen   = 8'd0;
    assign io_master.arlen   = 8'd0;
    assign io_master.awburst = BURST_INCR;
    assign io_master.arburst = BURST_INCR;
    assign io_master.awaddr  = addr_q;
    assign io_master.araddr  = addr_q;
    assign io_master.awsize  = {1'b0, size_q};
    assign io_master.arsize  = {1'b0, size_q};
    assign io_master.wdata   = wdata_q << {off, 3'b000};
    assign io_master.wstrb   = strb_base[STRB_W-1:0] << off;

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Next-state and handshake outputs for the transaction FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        next_state        = state_q;
        req_ready         = 1'b0;
        resp_valid        = 1'b0;
        accept            = 1'b0;
        aw_hs             = 1'b0;
        w_hs              = 1'b0;
        rd_capture        = 1'b0;
        b_capture         = 1'b0;
        to_fire           = 1'b0;
        io_master.arvalid = 1'b0;
        io_master.rready  = 1'b0;
        io_master.awvalid = 1'b0;
        io_master.wvalid  = 1'b0;
        io_master.wlast   = 1'b0;
        io_master.bready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_bad)      next_state = S_RESP;
                    else if (req_wen) next_state = S_AWW;
                    else              next_state = S_AR;
                end
            end
            S_AR: begin
                io_master.arvalid = 1'b1;
                if (io_master.arready) begin
                    next_state = S_R;
                end else if (timeout_hit) begin
                    to_fire    = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_R: begin
                io_master.rready = 1'b1;
                if (io_master.rvalid) begin
                    rd_capture = 1'b1;
                    next_state = S_RESP;
                end else if (timeout_hit) begin
                    to_fire    = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_AWW: begin
                io_master.awvalid = !aw_done_q;
                io_master.wvalid  = !w_done_q;
                io_master.wlast   = 1'b1;
                aw_hs = !aw_done_q && io_master.awready;
                w_hs  = !w_done_q && io_master.wready;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    next_state = S_B;
                end else if (timeout_hit) begin
                    to_fire    = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_B: begin
                io_master.bready = 1'b1;
                if (io_master.bvalid) begin
                    b_capture  = 1'b1;
                    next_state = S_RESP;
                end else if (timeout_hit) begin
                    to_fire    = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register, request latch, channel flags, timeout counter and response.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the datapath registers are reset as well, so every output
            // (addresses, data, strobes, response) is defined right after reset.
            state_q   <= S_IDLE;
            wen_q     <= 1'b0;
            sign_q    <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= ERR_OK;
        end else begin
            state_q <= next_state;

            if (accept) begin
                wen_q     <= req_wen;
                sign_q    <= req_sign;
                size_q    <= req_size;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                cnt_q     <= '0;
                rdata_q   <= '0;
                err_q     <= req_bad ? ERR_ALIGN : ERR_OK;
            end

            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;

            // saturates so a long wait cannot wrap back below the limit
            if (in_bus && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);

            if (rd_capture) begin
                rdata_q <= load_data;
                if (io_master.rresp != 2'b00) err_q <= ERR_BUS;
            end

            if (b_capture && (io_master.bresp != 2'b00)) err_q <= ERR_BUS;

            if (to_fire) err_q <= ERR_TIMEOUT;
        end
    end

    // rlast/rid/bid carry nothing for single-beat, single-ID traffic; wen_q is
    // implied by the state path and the upper extension bits exceed DATA_W=32.
    logic unused_ok;
    assign unused_ok = ^{io_master.rlast, io_master.rid, io_master.bid, wen_q, load_ext};

endmodule
